vga_pic_ctrl: RTL
=================

VGA_PIC_CTRL -- requirements
Module: vga_pic_ctrl

Interface
REQ-001 SHALL expose: vga_clk  in  1  25 MHz pixel clock.
REQ-002 SHALL expose: sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL expose: game_state  in  2  0=START, 1=PLAYING, 2=VICTORY, 3=FAIL.
REQ-004 SHALL expose: cell_state  in  4  state of cell (curr_cell_x, curr_cell_y), combinational from map.
REQ-005 SHALL expose: start_pic_data, victory_pic_data, fail_pic_data  in  16 each  image ROM data, 1-cycle latency.
REQ-006 SHALL expose: zero..eight_cell_data, mine_cell_data, flag_cell_data, unshown_cell_data  in  16 each  cell ROM data, 1-cycle latency.
REQ-007 SHALL expose: addr_h, addr_v  out  12 each  active-area pixel coordinate driven to image drive.
REQ-008 SHALL expose: curr_cell_x, curr_cell_y  out  3 each  grid cell under addr_h/addr_v.
REQ-009 SHALL expose: hsync, vsync  out  1 each  active-low sync.
REQ-010 SHALL expose: rgb  out  16  RGB565 pixel, aligned to hsync/vsync.

Function
REQ-011 Timing 640x480@60: H total 800 = sync 96, back 48, active 640, front 16; V total 525 = sync 2, back 33, active 480, front 10.
REQ-012 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment on h_cnt wrap, count 0..524, wrap to 0.
REQ-013 Stage 0: hsync_0 low when h_cnt<96; vsync_0 low when v_cnt<2; active_0 when h_cnt in [144,783] and v_cnt in [35,514].
REQ-014 addr_h = h_cnt-144 and addr_v = v_cnt-35 while active_0; both 0 otherwise.
REQ-015 Picture region: addr_h in [256,383], addr_v in [176,303] (128x128).
REQ-016 Grid region: addr_h in [192,447], addr_v in [112,367]; 8x8 cells of 32x32.
REQ-017 curr_cell_x = (addr_h-192)>>5, curr_cell_y = (addr_v-112)>>5 inside grid; 0 outside.
REQ-018 Stage 1: active, sync, region flags, game_state and cell_state SHALL be registered one cycle to match ROM latency.
REQ-019 Stage 2: rgb, hsync, vsync registered; total latency from counter to pins = 2 cycles, sync and rgb mutually aligned.
REQ-020 Select, stage-1 values: not active -> 0; START/VICTORY/FAIL in picture region -> start/victory/fail_pic_data; same states outside picture -> BG_COLOR 16'h0000.
REQ-021 PLAYING in grid region: cell_state 0..8 -> zero..eight_cell_data, 9 -> mine, 10 -> flag, 11..15 -> unshown_cell_data; outside grid -> BG_COLOR.
REQ-022 game_state change mid-frame SHALL take effect on the next pixel (no frame holding); source switch glitch-free per pixel.
REQ-023 Boundary: pixel at grid x=447/y=367 SHALL be cell (7,7); x=448 SHALL be background.

Reset
REQ-024 On sys_rst_n low, immediately: h_cnt=0, v_cnt=0, all pipeline registers cleared, hsync=1, vsync=1, rgb=0, addr_h=addr_v=0, curr_cell_x=curr_cell_y=0.
REQ-025 After release, first hsync low SHALL appear 2 cycles after first rising edge; reset mid-frame restarts frame at h_cnt=0,v_cnt=0.

Structure
REQ-026 Timing constants, region origins/sizes, BG_COLOR, game_state and cell_state codes SHALL live in parameter.v as `define.
REQ-027 Counters and stage-0 sync/active SHALL be a sub-module vga_timing; vga_pic_ctrl instantiates it plus select pipeline.

Verification
REQ-028 Reset release, run 1 line -> hsync low for cycles 2..97 after release, period 800 cycles.
REQ-029 Run 1 frame -> vsync low exactly 2 lines (1600 cycles), frame period 420000 cycles.
REQ-030 game_state=START, ROM model data=addr -> pixel (256,176) rgb equals ROM word at pic_addr 0, two cycles after addr presented.
REQ-031 PLAYING, cell_state=9 for cell (3,4) -> pixels x 288..319, y 240..271 show mine_cell_data; cell_state=13 -> unshown_cell_data.
REQ-032 PLAYING, pixel (448,200) and blanking -> rgb=0; (447,367) -> curr_cell_x=7, curr_cell_y=7.
REQ-033 Assert sys_rst_n low at h_cnt=400,v_cnt=200 -> outputs reset same cycle; after release counters restart from 0.

Source files
------------

// File: rtl/vga_pic_ctrl_pkg.sv
// Shared constants for the VGA picture controller: 640x480@60 timing,
// screen regions, background colour and game/cell state codes.
package vga_pic_ctrl_pkg;

  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BACK   = 10'd48;
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FRONT  = 10'd16;
  localparam logic [9:0] H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;

  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BACK   = 10'd33;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FRONT  = 10'd10;
  localparam logic [9:0] V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [9:0] H_ACT_START = H_SYNC + H_BACK;
  localparam logic [9:0] H_ACT_END   = H_ACT_START + H_ACTIVE - 10'd1;
  localparam logic [9:0] V_ACT_START = V_SYNC + V_BACK;
  localparam logic [9:0] V_ACT_END   = V_ACT_START + V_ACTIVE - 10'd1;

  localparam logic [11:0] PIC_X0    = 12'd256;
  localparam logic [11:0] PIC_Y0    = 12'd176;
  localparam logic [11:0] PIC_SIZE  = 12'd128;
  localparam logic [11:0] GRID_X0   = 12'd192;
  localparam logic [11:0] GRID_Y0   = 12'd112;
  localparam logic [11:0] GRID_SIZE = 12'd256;
  localparam int          CELL_SHIFT = 5;

  localparam logic [15:0] BG_COLOR = 16'h0000;

  typedef enum logic [1:0] {
    GS_START   = 2'd0,
    GS_PLAYING = 2'd1,
    GS_VICTORY = 2'd2,
    GS_FAIL    = 2'd3
  } game_state_e;

  localparam logic [3:0] CELL_MINE = 4'd9;
  localparam logic [3:0] CELL_FLAG = 4'd10;

  // Square region test; origin + size never exceeds 12 bits for our regions.
  function automatic logic in_box(input logic [11:0] x, input logic [11:0] y,
                                  input logic [11:0] x0, input logic [11:0] y0,
                                  input logic [11:0] size);
    return (x >= x0) && (x < x0 + size) && (y >= y0) && (y < y0 + size);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical counters plus the raw (stage-0) sync and active flags
// for 640x480@60.
module vga_timing
  import vga_pic_ctrl_pkg::*;
(
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync_0,
  output logic       vsync_0,
  output logic       active_0
);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOTAL - 10'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign hsync_0  = (h_cnt >= H_SYNC);
  assign vsync_0  = (v_cnt >= V_SYNC);
  assign active_0 = (h_cnt >= H_ACT_START) && (h_cnt <= H_ACT_END) &&
                    (v_cnt >= V_ACT_START) && (v_cnt <= V_ACT_END);

endmodule

// File: rtl/vga_pic_ctrl.sv
// Minesweeper VGA front end: maps the scan position to picture/grid regions,
// selects ROM data by game and cell state, and aligns rgb with the syncs.
module vga_pic_ctrl
  import vga_pic_ctrl_pkg::*;
(
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  game_state,
  input  logic [3:0]  cell_state,
  input  logic [15:0] start_pic_data,
  input  logic [15:0] victory_pic_data,
  input  logic [15:0] fail_pic_data,
  input  logic [15:0] zero_cell_data,
  input  logic [15:0] one_cell_data,
  input  logic [15:0] two_cell_data,
  input  logic [15:0] three_cell_data,
  input  logic [15:0] four_cell_data,
  input  logic [15:0] five_cell_data,
  input  logic [15:0] six_cell_data,
  input  logic [15:0] seven_cell_data,
  input  logic [15:0] eight_cell_data,
  input  logic [15:0] mine_cell_data,
  input  logic [15:0] flag_cell_data,
  input  logic [15:0] unshown_cell_data,
  output logic [11:0] addr_h,
  output logic [11:0] addr_v,
  output logic [2:0]  curr_cell_x,
  output logic [2:0]  curr_cell_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb
);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        hsync_0;
  logic        vsync_0;
  logic        active_0;
  logic        in_pic_0;
  logic        in_grid_0;
  logic [11:0] grid_dx;
  logic [11:0] grid_dy;

  logic        active_1;
  logic        hsync_1;
  logic        vsync_1;
  logic        in_pic_1;
  logic        in_grid_1;
  game_state_e game_1;
  logic [3:0]  cell_1;
  logic [15:0] pix_next;

  vga_timing u_timing (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .hsync_0  (hsync_0),
    .vsync_0  (vsync_0),
    .active_0 (active_0)
  );

  always_comb begin
    addr_h = '0;
    addr_v = '0;
    if (active_0) begin
      addr_h = {2'b00, h_cnt - H_ACT_START};
      addr_v = {2'b00, v_cnt - V_ACT_START};
    end
  end

  // Blanking forces the address to 0, which lies outside both regions.
  assign in_pic_0  = in_box(addr_h, addr_v, PIC_X0, PIC_Y0, PIC_SIZE);
  assign in_grid_0 = in_box(addr_h, addr_v, GRID_X0, GRID_Y0, GRID_SIZE);
  assign grid_dx   = addr_h - GRID_X0;
  assign grid_dy   = addr_v - GRID_Y0;
  assign curr_cell_x = in_grid_0 ? 3'(grid_dx >> CELL_SHIFT) : '0;
  assign curr_cell_y = in_grid_0 ? 3'(grid_dy >> CELL_SHIFT) : '0;

  // Stage 1 lines the region flags and states up with the ROM words,
  // which arrive one cycle after the address.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active_1  <= 1'b0;
      hsync_1   <= 1'b1;
      vsync_1   <= 1'b1;
      in_pic_1  <= 1'b0;
      in_grid_1 <= 1'b0;
      game_1    <= GS_START;
      cell_1    <= '0;
    end else begin
      active_1  <= active_0;
      hsync_1   <= hsync_0;
      vsync_1   <= vsync_0;
      in_pic_1  <= in_pic_0;
      in_grid_1 <= in_grid_0;
      game_1    <= game_state_e'(game_state);
      cell_1    <= cell_state;
    end
  end

  always_comb begin
    pix_next = '0;
    if (active_1) begin
      unique case (game_1)
        GS_START:   pix_next = in_pic_1 ? start_pic_data   : BG_COLOR;
        GS_VICTORY: pix_next = in_pic_1 ? victory_pic_data : BG_COLOR;
        GS_FAIL:    pix_next = in_pic_1 ? fail_pic_data    : BG_COLOR;
        GS_PLAYING: begin
          pix_next = BG_COLOR;
          if (in_grid_1) begin
            case (cell_1)
              4'd0:      pix_next = zero_cell_data;
              4'd1:      pix_next = one_cell_data;
              4'd2:      pix_next = two_cell_data;
              4'd3:      pix_next = three_cell_data;
              4'd4:      pix_next = four_cell_data;
              4'd5:      pix_next = five_cell_data;
              4'd6:      pix_next = six_cell_data;
              4'd7:      pix_next = seven_cell_data;
              4'd8:      pix_next = eight_cell_data;
              CELL_MINE: pix_next = mine_cell_data;
              CELL_FLAG: pix_next = flag_cell_data;
              default:   pix_next = unshown_cell_data;
            endcase
          end
        end
        default: pix_next = BG_COLOR;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else begin
      hsync <= hsync_1;
      vsync <= vsync_1;
      rgb   <= pix_next;
    end
  end

endmodule
